// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller: 8-entry data array with an external tag
// memory and a single outstanding main-memory fill. All outputs are registered.
module cache_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_busy,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              tag_en,
  output logic [2:0]        tag_idx,
  output logic [2:0]        tag_tag,
  input  logic              tag_hit,
  input  logic              tag_miss,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, MEM_REQ} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_arr [8];
  logic [2:0]        idx;

  logic              busy_nxt, ready_nxt, err_nxt, tag_en_nxt, mem_rd_nxt, fill;
  logic [2:0]        tag_idx_nxt, tag_tag_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] rdata_nxt;

  assign idx = addr_q[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      cpu_busy  <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      tag_en    <= 1'b0;
      mem_rd    <= 1'b0;
      tag_idx   <= '0;
      tag_tag   <= '0;
      mem_addr  <= '0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      cpu_busy  <= busy_nxt;
      cpu_ready <= ready_nxt;
      cpu_err   <= err_nxt;
      tag_en    <= tag_en_nxt;
      mem_rd    <= mem_rd_nxt;
      tag_idx   <= tag_idx_nxt;
      tag_tag   <= tag_tag_nxt;
      mem_addr  <= mem_addr_nxt;
      cpu_rdata <= rdata_nxt;
    end
  end

  // Validity lives in the tag memory, so the data array itself is never cleared.
  always_ff @(posedge clk) begin
    if (fill && !rst) data_arr[idx] <= mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = CHECK;
      CHECK:   state_nxt = (tag_miss && !tag_hit) ? MEM_REQ : IDLE;
      MEM_REQ: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Computes the next value of every registered output; pulses default low.
  always_comb begin
    addr_nxt     = addr_q;
    busy_nxt     = (state_nxt != IDLE);
    ready_nxt    = 1'b0;
    err_nxt      = 1'b0;
    tag_en_nxt   = 1'b0;
    mem_rd_nxt   = mem_rd;
    tag_idx_nxt  = tag_idx;
    tag_tag_nxt  = tag_tag;
    mem_addr_nxt = mem_addr;
    rdata_nxt    = cpu_rdata;
    fill         = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          addr_nxt    = cpu_addr;
          tag_en_nxt  = 1'b1;
          tag_idx_nxt = cpu_addr[2:0];
          tag_tag_nxt = cpu_addr[5:3];
        end
      end
      CHECK: begin
        if (tag_hit && !tag_miss) begin
          rdata_nxt = data_arr[idx];
          ready_nxt = 1'b1;
        end else if (tag_miss && !tag_hit) begin
          mem_rd_nxt   = 1'b1;
          mem_addr_nxt = addr_q;
        end else begin
          err_nxt = 1'b1;
        end
      end
      MEM_REQ: begin
        if (mem_ack) begin
          fill       = 1'b1;
          rdata_nxt  = mem_rdata;
          mem_rd_nxt = 1'b0;
          ready_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: the bench plays both tag memory and main memory,
// and every expected value below is written out by hand.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req;
  logic [5:0] cpu_addr;
  logic       cpu_busy, cpu_ready, cpu_err;
  logic [7:0] cpu_rdata;
  logic       tag_en;
  logic [2:0] tag_idx, tag_tag;
  logic       tag_hit, tag_miss;
  logic       mem_rd;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int checks = 0;
  int fails  = 0;
  logic [7:0] expRdata = 8'h00;

  localparam int MISS = 0, HIT = 1, NONE = 2, BOTH = 3;

  cache_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_busy(cpu_busy),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .tag_en(tag_en), .tag_idx(tag_idx), .tag_tag(tag_tag),
    .tag_hit(tag_hit), .tag_miss(tag_miss),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU read: request edge T, lookup, tag response in CHECK, then hit/miss/error.
  // If 'last' is 0 the caller issues the next request in the cpu_ready cycle.
  task automatic applyStimulus(input logic [5:0] a, input int mode, input int ackDelay,
                               input logic [7:0] val, input bit holdReq, input bit last);
    cpu_addr = a;
    cpu_req  = 1'b1;
    tick;
    cpu_req  = 1'b0;
    checkOutput("lookup_tag_en", tag_en, 1);
    checkOutput("lookup_tag_idx", tag_idx, a[2:0]);
    checkOutput("lookup_tag_tag", tag_tag, a[5:3]);
    checkOutput("lookup_busy", cpu_busy, 1);
    tick;
    tag_hit  = (mode == HIT || mode == BOTH);
    tag_miss = (mode == MISS || mode == BOTH);
    checkOutput("check_tag_en", tag_en, 0);
    if (holdReq) begin
      cpu_req  = 1'b1;
      cpu_addr = 6'h07;
    end
    tick;
    tag_hit  = 1'b0;
    tag_miss = 1'b0;
    if (mode == HIT) begin
      expRdata = val;
      checkOutput("hit_ready", cpu_ready, 1);
      checkOutput("hit_rdata", cpu_rdata, expRdata);
      checkOutput("hit_no_mem_rd", mem_rd, 0);
      checkOutput("hit_busy", cpu_busy, 0);
    end else if (mode == NONE || mode == BOTH) begin
      checkOutput("err_pulse", cpu_err, 1);
      checkOutput("err_no_ready", cpu_ready, 0);
      checkOutput("err_rdata_held", cpu_rdata, expRdata);
      checkOutput("err_no_mem_rd", mem_rd, 0);
      checkOutput("err_busy", cpu_busy, 0);
    end else begin
      checkOutput("miss_mem_rd", mem_rd, 1);
      checkOutput("miss_mem_addr", mem_addr, a);
      checkOutput("miss_busy", cpu_busy, 1);
      checkOutput("miss_no_ready", cpu_ready, 0);
      for (int i = 0; i < ackDelay; i++) begin
        tick;
        checkOutput("wait_mem_rd", mem_rd, 1);
        checkOutput("wait_mem_addr", mem_addr, a);
        checkOutput("wait_no_tag_en", tag_en, 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = val;
      tick;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      cpu_req   = 1'b0;
      expRdata  = val;
      checkOutput("fill_ready", cpu_ready, 1);
      checkOutput("fill_rdata", cpu_rdata, expRdata);
      checkOutput("fill_mem_rd_low", mem_rd, 0);
      checkOutput("fill_busy", cpu_busy, 0);
    end
    if (last) begin
      tick;
      checkOutput("after_ready_low", cpu_ready, 0);
      checkOutput("after_err_low", cpu_err, 0);
      checkOutput("after_busy", cpu_busy, 0);
      checkOutput("after_mem_rd", mem_rd, 0);
      checkOutput("after_rdata", cpu_rdata, expRdata);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 6'h00;
    tag_hit = 1'b0; tag_miss = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    checkOutput("rst_busy", cpu_busy, 0);
    checkOutput("rst_ready", cpu_ready, 0);
    checkOutput("rst_err", cpu_err, 0);
    checkOutput("rst_tag_en", tag_en, 0);
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_tag_idx", tag_idx, 0);
    checkOutput("rst_tag_tag", tag_tag, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_rdata", cpu_rdata, 0);

    $display("[TB] cold miss, hit, conflict");
    applyStimulus(6'h2A, MISS, 3, 8'hA5, 1'b0, 1'b1);
    applyStimulus(6'h2A, HIT,  0, 8'hA5, 1'b0, 1'b1);
    applyStimulus(6'h12, MISS, 1, 8'h3C, 1'b0, 1'b1);
    applyStimulus(6'h12, HIT,  0, 8'h3C, 1'b0, 1'b0);
    applyStimulus(6'h2A, MISS, 0, 8'h5A, 1'b0, 1'b0);
    applyStimulus(6'h2A, HIT,  0, 8'h5A, 1'b0, 1'b1);

    $display("[TB] protocol errors");
    applyStimulus(6'h2A, NONE, 0, 8'h00, 1'b0, 1'b1);
    applyStimulus(6'h12, BOTH, 0, 8'h00, 1'b0, 1'b1);

    $display("[TB] busy drop");
    applyStimulus(6'h21, MISS, 2, 8'h99, 1'b1, 1'b1);
    applyStimulus(6'h07, MISS, 0, 8'h77, 1'b0, 1'b1);
    applyStimulus(6'h07, HIT,  0, 8'h77, 1'b0, 1'b1);

    $display("[TB] reset during fill");
    cpu_addr = 6'h30;
    cpu_req  = 1'b1;
    tick;
    cpu_req  = 1'b0;
    tick;
    tag_miss = 1'b1;
    tick;
    tag_miss = 1'b0;
    checkOutput("rm_mem_rd", mem_rd, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    expRdata = 8'h00;
    checkOutput("rm_mem_rd_dropped", mem_rd, 0);
    checkOutput("rm_busy", cpu_busy, 0);
    checkOutput("rm_rdata", cpu_rdata, expRdata);
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    checkOutput("rm_late_ack_ready", cpu_ready, 0);
    checkOutput("rm_late_ack_rdata", cpu_rdata, expRdata);
    checkOutput("rm_late_ack_busy", cpu_busy, 0);
    tick;
    checkOutput("rm_late_ack_ready2", cpu_ready, 0);

    $display("[TB] data array survives reset");
    applyStimulus(6'h2A, HIT, 0, 8'h5A, 1'b0, 1'b1);
    applyStimulus(6'h21, HIT, 0, 8'h99, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the width of the data word in the cache line and in main memory.
REQ-002 SHALL have parameter ADDR_W, default 6, the CPU byte address width; bits [5:3] are the tag and bits [2:0] are the index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cpu_req, input, 1 bit: read request, sampled only in IDLE.
REQ-006 SHALL have port cpu_addr, input, ADDR_W bits: request address, captured when the request is accepted.
REQ-007 SHALL have port cpu_busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port cpu_ready, output, 1 bit: one-cycle pulse marking cpu_rdata valid.
REQ-009 SHALL have port cpu_rdata, output, DATA_W bits: read data, held until the next fill or hit.
REQ-010 SHALL have port cpu_err, output, 1 bit: one-cycle pulse on a tag-response protocol error.
REQ-011 SHALL have port tag_en, output, 1 bit: lookup strobe to the tag memory.
REQ-012 SHALL have port tag_idx, output, 3 bits: index sent to the tag memory.
REQ-013 SHALL have port tag_tag, output, 3 bits: tag sent to the tag memory.
REQ-014 SHALL have port tag_hit, input, 1 bit: registered hit response from the tag memory.
REQ-015 SHALL have port tag_miss, input, 1 bit: registered miss response from the tag memory.
REQ-016 SHALL have port mem_rd, output, 1 bit: main-memory read request, held as a level until acknowledged.
REQ-017 SHALL have port mem_addr, output, ADDR_W bits: main-memory address.
REQ-018 SHALL have port mem_rdata, input, DATA_W bits: main-memory read data, valid when mem_ack is high.
REQ-019 SHALL have port mem_ack, input, 1 bit: main-memory acknowledge.

Function
REQ-020 SHALL implement the states IDLE, LOOKUP, CHECK and MEM_REQ, all with registered outputs.
REQ-021 SHALL, in IDLE with cpu_req=1 at edge T, latch cpu_addr and enter LOOKUP at T+1.
REQ-022 SHALL, in LOOKUP, drive tag_en=1 for exactly one cycle with tag_idx=addr[2:0] and tag_tag=addr[5:3], then enter CHECK.
REQ-023 SHALL, in CHECK on tag_hit=1 and tag_miss=0, load cpu_rdata from data_arr[idx], pulse cpu_ready and return to IDLE, so that hit latency is request at T and cpu_ready at T+3.
REQ-024 SHALL, in CHECK on tag_miss=1 and tag_hit=0, enter MEM_REQ with mem_rd=1 and mem_addr=latched addr.
REQ-025 SHALL, in CHECK with tag_hit equal to tag_miss (both 0 or both 1), pulse cpu_err, leave cpu_rdata and data_arr unchanged, and return to IDLE.
REQ-026 SHALL hold mem_rd and mem_addr stable in MEM_REQ until mem_ack=1 is sampled, with no timeout.
REQ-027 SHALL, on a sampled mem_ack, write mem_rdata into data_arr[idx] and cpu_rdata, drop mem_rd, pulse cpu_ready next cycle and return to IDLE.
REQ-028 SHALL ignore mem_ack outside MEM_REQ.
REQ-029 SHALL ignore tag_hit and tag_miss outside CHECK.
REQ-030 SHALL ignore cpu_req while cpu_busy=1; dropped requests are neither queued nor flagged.
REQ-031 SHALL accept a new cpu_req in the same cycle that cpu_ready is high, since the state is IDLE in that cycle.
REQ-032 SHALL hold the data array as 8 x DATA_W internal storage, indexed by addr[2:0] and written only on a fill.
REQ-033 SHALL use direct-mapped replacement: a miss overwrites data_arr[idx] unconditionally, and there is no write path from the CPU.

Reset
REQ-034 SHALL, on a clk edge with rst=1, enter IDLE and clear cpu_busy, cpu_ready, cpu_err, tag_en, mem_rd, tag_idx, tag_tag, mem_addr and cpu_rdata to 0.
REQ-035 SHALL NOT reset data_arr, because validity is owned by the tag memory, which clears on the same rst.
REQ-036 SHALL, on a reset during MEM_REQ, drop mem_rd the next cycle, ignore any later mem_ack, and produce no cpu_ready.

Verification
REQ-037 Cold miss: after reset, cpu_req with addr 0x2A (tag 5, idx 2) -> tag_en at T+1, mem_rd=1 with mem_addr=0x2A, mem_ack with mem_rdata=0xA5 after 3 cycles -> cpu_ready with cpu_rdata=0xA5, and mem_rd low afterwards.
REQ-038 Hit: re-read 0x2A -> cpu_ready at T+3 with 0xA5, and mem_rd never asserted.
REQ-039 Conflict: read 0x12 (tag 2, idx 2) -> miss filled with 0x3C; then read 0x2A -> miss again with a new mem_rd.
REQ-040 Protocol error: tag_hit=0 and tag_miss=0 in CHECK -> cpu_err pulses for 1 cycle, no cpu_ready, and cpu_rdata unchanged.
REQ-041 Busy drop: cpu_req with addr 0x07 held high during MEM_REQ -> ignored; after the fill, cpu_busy=0, and a fresh 0x07 request is processed normally.
REQ-042 Reset mid-miss: rst=1 for 1 cycle while mem_rd=1 -> mem_rd=0 the next cycle; a later mem_ack produces no cpu_ready.
